// File: rtl/mem_write_checker.sv
// Table-driven end-of-program checker: snoops the memory-stage write bus, keeps the last
// value written to each programmed address and grades the table after halt or watchdog.
module mem_write_checker #(
  parameter int          N_CHECKS     = 4,
  parameter int          ADDR_W       = 32,
  parameter int          DATA_W       = 32,
  parameter logic [31:0] HALT_PC      = 32'h0000_00F4,
  parameter int          TIMEOUT      = 2000,
  parameter int          DRAIN_CYCLES = 10,
  localparam int         IDX_W        = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] DataAdrM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [31:0]       PCF,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W:0]    fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CHECKS - 1);
  localparam logic [IDX_W:0]   N_ENTRIES = (IDX_W + 1)'(N_CHECKS);

  logic [2:0]          state;
  logic [ADDR_W-1:0]   exp_addr [N_CHECKS];
  logic [DATA_W-1:0]   exp_data [N_CHECKS];
  logic [DATA_W-1:0]   cap_data [N_CHECKS];
  logic [N_CHECKS-1:0] seen;
  logic [N_CHECKS-1:0] addr_hit;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [DRN_W-1:0]    drain_cnt;
  logic [IDX_W-1:0]    chk_idx;
  logic                snoop_en;
  logic                halt_hit;
  logic                wd_hit;
  logic                cfg_ok;
  logic                entry_fail;

  assign snoop_en   = (state == S_RUN) || (state == S_DRAIN);
  assign halt_hit   = (PCF == HALT_PC);
  assign wd_hit     = (cycle_cnt == CNT_LAST);
  assign cfg_ok     = cfg_we && ((state == S_IDLE) || (state == S_DONE)) &&
                      ({1'b0, cfg_idx} < N_ENTRIES);
  assign entry_fail = !seen[chk_idx] || (cap_data[chk_idx] != exp_data[chk_idx]);

  // Duplicate table addresses all match, so every hit entry captures the same write.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    addr_hit = '0;
    for (int i = 0; i < N_CHECKS; i++)
      addr_hit[i] = snoop_en && MemWriteM && (DataAdrM == exp_addr[i]);
  end

  // NOTE: table storage carries no reset; expected entries are reprogrammed after reset
  // and a captured value is only trusted while its seen bit is set.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      exp_addr[cfg_idx] <= cfg_addr;
      exp_data[cfg_idx] <= cfg_data;
    end
    for (int i = 0; i < N_CHECKS; i++)
      if (addr_hit[i]) cap_data[i] <= WriteDataM;
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      seen            <= '0;
      cycle_cnt       <= '0;
      drain_cnt       <= '0;
      chk_idx         <= '0;
      timeout         <= 1'b0;
      fail_count      <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
    end else begin
      seen <= seen | addr_hit;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_RUN;
            seen            <= '0;
            cycle_cnt       <= '0;
            drain_cnt       <= '0;
            chk_idx         <= '0;
            timeout         <= 1'b0;
            fail_count      <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (halt_hit) begin
            state <= (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;
          end else if (wd_hit) begin
            timeout <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_DRAIN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          drain_cnt <= drain_cnt + 1'b1;
          // Normal drain completion takes precedence over a coincident watchdog.
          if (drain_cnt == DRN_LAST) begin
            state <= S_CHECK;
          end else if (wd_hit) begin
            timeout <= 1'b1;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (entry_fail) begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0) begin
              first_fail_idx  <= chk_idx;
              first_fail_data <= seen[chk_idx] ? cap_data[chk_idx] : '0;
            end
          end
          chk_idx <= chk_idx + 1'b1;
          if (chk_idx == IDX_LAST) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == '0) && !timeout;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: scenario tasks drive programs on the write bus and compare
// the verdict with a last-write-wins memory model evaluated over the snoop window.
module tb_mem_write_checker;

  localparam int          N     = 4;
  localparam int          IDX_W = 2;
  localparam int          D     = 10;
  localparam int          TO_A  = 2000;
  localparam int          TO_WD = 50;
  localparam logic [31:0] HALT  = 32'h0000_00F4;
  localparam logic [31:0] MM_A [N] = '{32'h300, 32'h304, 32'h310, 32'h314};
  localparam logic [31:0] MM_D [N] = '{32'h41bf70a4, 32'h41e67ae2, 32'h424851eb, 32'h42710a3e};

  logic clk = 1'b0;
  logic reset, cfg_we, start, MemWriteM;
  logic [IDX_W-1:0] cfg_idx;
  logic [31:0] cfg_addr, cfg_data, DataAdrM, WriteDataM, PCF;

  logic busy_a, done_a, pass_a, timeout_a;
  logic [IDX_W:0] fc_a;
  logic [IDX_W-1:0] ffi_a;
  logic [31:0] ffd_a;
  logic busy_w, done_w, pass_w, timeout_w;
  logic [IDX_W:0] fc_w;
  logic [IDX_W-1:0] ffi_w;
  logic [31:0] ffd_w;

  logic sel_wd;
  logic o_busy, o_done, o_pass, o_to;
  logic [IDX_W:0] o_fc;
  logic [IDX_W-1:0] o_ffi;
  logic [31:0] o_ffd;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t prog[$];
  int cursor;
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM),
    .WriteDataM(WriteDataM), .PCF(PCF), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(timeout_a), .fail_count(fc_a), .first_fail_idx(ffi_a), .first_fail_data(ffd_a)
  );

  mem_write_checker #(.TIMEOUT(TO_WD)) dut_wd (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .MemWriteM(MemWriteM), .DataAdrM(DataAdrM),
    .WriteDataM(WriteDataM), .PCF(PCF), .busy(busy_w), .done(done_w), .pass(pass_w),
    .timeout(timeout_w), .fail_count(fc_w), .first_fail_idx(ffi_w), .first_fail_data(ffd_w)
  );

  always_comb begin
    o_busy = sel_wd ? busy_w    : busy_a;
    o_done = sel_wd ? done_w    : done_a;
    o_pass = sel_wd ? pass_w    : pass_a;
    o_to   = sel_wd ? timeout_w : timeout_a;
    o_fc   = sel_wd ? fc_w      : fc_a;
    o_ffi  = sel_wd ? ffi_w     : ffi_a;
    o_ffd  = sel_wd ? ffd_w     : ffd_a;
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom & 32'hFFFF_FFFC;
    if (p == HALT) p = p + 32'd4;
    return p;
  endfunction

  task automatic new_prog();
    prog.delete();
    cursor = 0;
  endtask

  task automatic push_at(input int c, input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.cyc = c; w.addr = a; w.data = d;
    prog.push_back(w);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    push_at(cursor, a, d);
    cursor += 1 + int'($urandom_range(0, 2));
  endtask

  task automatic push_distractor();
    push(32'h0000_1000 + ($urandom_range(0, 255) << 2), $urandom);
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    m_addr[idx] = a;
    m_data[idx] = d;
  endtask

  task automatic program_matmul();
    for (int i = 0; i < N; i++) cfg_write(i, MM_A[i], MM_D[i]);
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({busy_a, done_a, pass_a, timeout_a} !== 4'b0 || fc_a !== '0 || ffi_a !== '0 || ffd_a !== '0) begin
      n_bad++;
      $display("FAIL %s (dut): busy=%b done=%b pass=%b timeout=%b fail_count=%0d first_fail_idx=%0d first_fail_data=%h, required all zero",
               name, busy_a, done_a, pass_a, timeout_a, fc_a, ffi_a, ffd_a);
    end
    n_cmp++;
    if ({busy_w, done_w, pass_w, timeout_w} !== 4'b0 || fc_w !== '0 || ffi_w !== '0 || ffd_w !== '0) begin
      n_bad++;
      $display("FAIL %s (dut_wd): busy=%b done=%b pass=%b timeout=%b fail_count=%0d first_fail_idx=%0d first_fail_data=%h, required all zero",
               name, busy_w, done_w, pass_w, timeout_w, fc_w, ffi_w, ffd_w);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts a run, drives prog on the bus (halt at RUN cycle halt_at, -1 for never) and
  // grades the verdict against the model.
  task automatic run_scenario(input string name, input int halt_at, input bit wd);
    logic [31:0] mem [logic [31:0]];
    int to_lim, win_end, exp_k, done_k, bad_busy, exp_fc, exp_ffi;
    logic [31:0] exp_ffd;
    logic exp_to, exp_pass, ok;

    sel_wd   = wd;
    to_lim   = wd ? TO_WD : TO_A;
    exp_to   = (halt_at < 0) || (halt_at > to_lim - 1);
    win_end  = exp_to ? to_lim - 1 : halt_at + D;
    exp_k    = exp_to ? to_lim - 1 + N : halt_at + D + N;

    foreach (prog[i]) if (prog[i].cyc <= win_end) mem[prog[i].addr] = prog[i].data;
    exp_fc = 0; exp_ffi = 0; exp_ffd = '0;
    for (int i = 0; i < N; i++) begin
      ok = 1'b0;
      if (mem.exists(m_addr[i])) ok = (mem[m_addr[i]] == m_data[i]);
      if (!ok) begin
        if (exp_fc == 0) begin
          exp_ffi = i;
          exp_ffd = mem.exists(m_addr[i]) ? mem[m_addr[i]] : 32'h0;
        end
        exp_fc++;
      end
    end
    exp_pass = (exp_fc == 0) && !exp_to;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0 || o_to !== 1'b0 ||
        o_fc !== '0 || o_ffi !== '0 || o_ffd !== '0) begin
      n_bad++;
      $display("FAIL %s start: busy=%b done=%b pass=%b timeout=%b fail_count=%0d first_fail_idx=%0d first_fail_data=%h, required busy=1 rest 0",
               name, o_busy, o_done, o_pass, o_to, o_fc, o_ffi, o_ffd);
    end

    done_k = -1;
    bad_busy = 0;
    for (int k = 0; k < 300 && done_k < 0; k++) begin
      MemWriteM  = 1'b0;
      DataAdrM   = m_addr[$urandom_range(0, N - 1)];
      WriteDataM = $urandom;
      PCF        = (k == halt_at) ? HALT : rand_pc();
      cfg_we     = (k == 1);
      cfg_idx    = '0;
      cfg_addr   = $urandom;
      cfg_data   = $urandom;
      foreach (prog[i]) begin
        if (prog[i].cyc == k) begin
          MemWriteM = 1'b1; DataAdrM = prog[i].addr; WriteDataM = prog[i].data;
        end
      end
      @(negedge clk);
      if (o_busy && o_done) bad_busy++;
      if (o_done) done_k = k;
      else if (!o_busy) bad_busy++;
    end
    MemWriteM = 1'b0;
    cfg_we    = 1'b0;
    PCF       = rand_pc();

    n_cmp++;
    if (done_k != exp_k) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d required %0d (cycles after start, -1 = never)", name, done_k, exp_k);
    end
    n_cmp++;
    if (bad_busy != 0) begin
      n_bad++;
      $display("FAIL %s busy_done: %0d cycles with busy/done wrong, required 0", name, bad_busy);
    end
    if (done_k < 0) return;

    n_cmp++;
    if (o_pass !== exp_pass) begin
      n_bad++;
      $display("FAIL %s pass: got %b required %b", name, o_pass, exp_pass);
    end
    n_cmp++;
    if (o_to !== exp_to) begin
      n_bad++;
      $display("FAIL %s timeout: got %b required %b", name, o_to, exp_to);
    end
    n_cmp++;
    if (o_fc !== (IDX_W + 1)'(exp_fc)) begin
      n_bad++;
      $display("FAIL %s fail_count: got %0d required %0d", name, o_fc, exp_fc);
    end
    n_cmp++;
    if (o_ffi !== IDX_W'(exp_ffi) || o_ffd !== exp_ffd) begin
      n_bad++;
      $display("FAIL %s first_fail: got idx=%0d data=%h required idx=%0d data=%h",
               name, o_ffi, o_ffd, exp_ffi, exp_ffd);
    end

    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_pass !== exp_pass || o_fc !== (IDX_W + 1)'(exp_fc)) begin
      n_bad++;
      $display("FAIL %s hold: done=%b busy=%b pass=%b fail_count=%0d required done=1 busy=0 pass=%b fail_count=%0d",
               name, o_done, o_busy, o_pass, o_fc, exp_pass, exp_fc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_matmul_pass();
    new_prog();
    push_distractor();
    for (int i = 0; i < N; i++) begin
      push(MM_A[i], MM_D[i]);
      if ($urandom_range(0, 1) == 1) push_distractor();
    end
    run_scenario("matmul_pass", cursor + 1, 1'b0);
  endtask

  task automatic test_wrong_value();
    new_prog();
    for (int i = 0; i < N; i++) push(MM_A[i], (i == 2) ? 32'h424851ec : MM_D[i]);
    run_scenario("wrong_value", cursor, 1'b0);
  endtask

  task automatic test_missing_write();
    new_prog();
    push(MM_A[0], MM_D[0]);
    push(MM_A[1], 32'h0);
    push(MM_A[2], MM_D[2]);
    push(MM_A[1], MM_D[1]);
    run_scenario("missing_write", cursor + 2, 1'b0);
  endtask

  task automatic test_watchdog();
    new_prog();
    for (int i = 0; i < N; i++) push(MM_A[i], MM_D[i]);
    run_scenario("watchdog", -1, 1'b1);
    pulse_reset();
    check_all_zero("watchdog_cleanup");
    program_matmul();
  endtask

  task automatic test_late_write();
    int h;
    for (int late = 5; late <= 11; late += 6) begin
      new_prog();
      for (int i = 0; i < N - 1; i++) push(MM_A[i], MM_D[i]);
      h = cursor;
      push_at(h + late, MM_A[3], MM_D[3]);
      run_scenario((late == 5) ? "late_write_in_drain" : "late_write_after_drain", h, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    test_wrong_value();
    pulse_reset();
    check_all_zero("reset_in_done");
    program_matmul();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      MemWriteM = 1'b1; DataAdrM = MM_A[k]; WriteDataM = MM_D[k]; PCF = rand_pc();
      @(negedge clk);
    end
    MemWriteM = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_mid_run");
    program_matmul();
    test_matmul_pass();
  endtask

  task automatic test_rearm();
    test_wrong_value();
    new_prog();
    for (int i = 0; i < N - 1; i++) push(MM_A[i], MM_D[i]);
    run_scenario("rearm_seen_cleared", cursor, 1'b0);
    test_matmul_pass();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        cfg_write(i, 32'h300 + ($urandom_range(0, 7) << 2), 32'hC0DE_0000 + $urandom_range(0, 3));
      if (it == 0) cfg_write(3, m_addr[1], m_data[1]);
      new_prog();
      for (int w = 0; w < 8; w++)
        push(32'h300 + ($urandom_range(0, 7) << 2), 32'hC0DE_0000 + $urandom_range(0, 3));
      run_scenario("random", $urandom_range(2, 25), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    MemWriteM = 1'b0; DataAdrM = '0; WriteDataM = '0; PCF = '0; sel_wd = 1'b0;
    test_reset();
    program_matmul();
    test_matmul_pass();
    test_wrong_value();
    test_missing_write();
    test_watchdog();
    test_late_write();
    test_reset_mid_run();
    test_rearm();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-check block for the pipelined RISC-V core. It snoops the memory-stage write bus (`MemWriteM`, `DataAdrM`, `WriteDataM`) and the fetch PC (`PCF`) and captures the last value written to each of N programmable addresses. When the program reaches a halt PC, or a cycle watchdog expires, it compares the captured values against an expected table and reports pass/fail. It generalises the fixed matmul result check to a parametrised, table-driven, re-armable checker usable on FPGA and in regression.

## Interface
Parameters:
- `N_CHECKS`, 4: number of expected-value entries (≥1).
- `ADDR_W`, 32: width of the snooped address and of each table address.
- `DATA_W`, 32: width of the snooped data and of each table value.
- `HALT_PC`, 32'h000000F4: fetch PC that marks program end.
- `TIMEOUT`, 2000: maximum number of RUN+DRAIN cycles before forced check (≥2).
- `DRAIN_CYCLES`, 10: cycles to keep snooping after halt detection (≥0).
- Derived: `IDX_W = max(1, clog2(N_CHECKS))`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write one expected-table entry.
- `cfg_idx` in IDX_W: entry index.
- `cfg_addr` in ADDR_W: expected byte address.
- `cfg_data` in DATA_W: expected value.
- `start` in 1: arm the checker (single-cycle pulse).
- `MemWriteM` in 1: memory-stage write strobe.
- `DataAdrM` in ADDR_W: memory-stage byte address.
- `WriteDataM` in DATA_W: memory-stage write data.
- `PCF` in 32: fetch PC.
- `busy` out 1: high in RUN, DRAIN and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done` is high.
- `timeout` out 1: watchdog fired in the current or last run.
- `fail_count` out IDX_W+1: number of failing entries.
- `first_fail_idx` out IDX_W: lowest failing index.
- `first_fail_data` out DATA_W: captured value at `first_fail_idx`; 0 if that entry was never written.

## Operation
- **Table:**
  - Per entry: expected address, expected value, captured value, seen bit.
  - `cfg_we` is accepted only in IDLE or DONE; it is ignored in all other states.
  - Writing an index ≥ N_CHECKS is ignored.
- **States:** IDLE, RUN, DRAIN, CHECK, DONE.
- **IDLE:**
  - On `start`: clear all seen bits, `fail_count`, `first_fail_*`, `timeout` and the cycle counter, then go to RUN.
- **RUN:**
  - Snoop the write bus every cycle.
  - Increment the cycle counter every cycle.
  - If `PCF == HALT_PC`, go to DRAIN.
  - Otherwise, if the counter reaches TIMEOUT-1, set `timeout` and go to CHECK.
  - If halt and watchdog occur in the same cycle, halt wins.
  - `start` is ignored in RUN.
- **Snoop:**
  - When `MemWriteM` is high, every entry whose address equals `DataAdrM` (full ADDR_W compare) captures `WriteDataM` and sets its seen bit.
  - Last write wins.
  - Duplicate table addresses all capture.
- **DRAIN:**
  - Snoop continues and the counter keeps running.
  - After DRAIN_CYCLES cycles, go to CHECK.
  - If the watchdog expires during DRAIN, set `timeout` and go to CHECK early.
  - With DRAIN_CYCLES=0, RUN goes directly to CHECK.
- **CHECK:**
  - Evaluate one entry per cycle, index 0 to N_CHECKS-1. No snooping.
  - An entry passes when it is seen and its captured value equals the expected value.
  - On the first failure, latch `first_fail_idx` and `first_fail_data`.
  - Every failure increments `fail_count`.
  - After the last index, go to DONE.
- **DONE:**
  - `pass = (fail_count == 0) && !timeout`.
  - All results hold until `start`, which re-arms exactly as from IDLE, or until reset.
  - The table contents are retained across re-arm.
- **Reset:**
  - From any state, including mid-RUN or mid-CHECK, go to IDLE.
  - All outputs become 0, seen bits are cleared, the counter is cleared.
  - Table expected values are don't-care after reset; software reprograms them.

## Timing
- All state updates occur at posedge `clk`; there are no combinational paths from inputs to outputs.
- A snooped write on the bus at posedge k is visible in the captured value from cycle k+1.
- A halt sampled at posedge h moves the FSM to DRAIN, which lasts DRAIN_CYCLES cycles.
- CHECK lasts N_CHECKS cycles.
- `done` rises at cycle h+1+DRAIN_CYCLES+N_CHECKS.
- On watchdog, `done` rises N_CHECKS+1 cycles after the expiring cycle, and `timeout` is high from that same cycle onward.
- `busy` and `done` are never both high.
- A snooped write in the same cycle the FSM leaves DRAIN is still captured.

## Test plan
1. **Matmul pass.** Program addresses 0x300, 0x304, 0x310, 0x314 with values 41bf70a4, 41e67ae2, 424851eb, 42710a3e. Pulse `start`, drive those four writes, then drive PCF=0xF4.
   - Required: `done` at h+15, `pass`=1, `fail_count`=0.
2. **Wrong value.** Same as scenario 1, but entry 2 is written with 424851ec.
   - Required: `pass`=0, `fail_count`=1, `first_fail_idx`=2, `first_fail_data`=424851ec.
3. **Missing write and last-write-wins.** Write 0x304 twice (00000000 then 41e67ae2) and never write 0x314.
   - Required: entry 1 passes; `fail_count`=1, `first_fail_idx`=3, `first_fail_data`=0.
4. **Watchdog.** TIMEOUT=50, all correct writes performed, PCF never reaches 0xF4.
   - Required: `timeout`=1, `pass`=0, `fail_count`=0, `done` 5 cycles after the expiring cycle.
5. **Late write in DRAIN.** Write 0x314 = 42710a3e 5 cycles after halt.
   - Required: `pass`=1.
   - Same write 11 cycles after halt: `fail_count`=1.
6. **Reset and re-arm.**
   - Assert reset mid-RUN: all outputs 0 the next cycle, FSM in IDLE.
   - Separately, `start` in DONE: `busy`=1 the next cycle, results and seen bits cleared, a subsequent clean run gives `pass`=1.
